// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter driving the register-file write port (A3/WD3/WE3).
// Optional build macro REGFILE_ARB_DROP_R0_EN: writes to register 0 are accepted but never issued.
module regfile_write_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic [AW-1:0] A3,
    output logic [DW-1:0] WD3,
    output logic          WE3,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_e;
    typedef enum logic [1:0] {AGE_NONE, AGE_A_OLD, AGE_B_OLD} age_e;

    state_e        state_q, state_d;
    age_e          age_q, age_d;
    logic          rr_q, rr_d;
    logic          full_a_q, full_a_d;
    logic          full_b_q, full_b_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [AW-1:0] addr_b_q, addr_b_d;
    logic [DW-1:0] data_a_q, data_a_d;
    logic [DW-1:0] data_b_q, data_b_d;
    logic [AW-1:0] a3_q, a3_d;
    logic [DW-1:0] wd3_q, wd3_d;

    logic drop_a, drop_b;
    logic elig_a, elig_b;
    logic tie;
    logic issue_a, issue_b;
    logic acc_a, acc_b;
    logic stay_a, stay_b;

    // Selection is decoded from registered state only, so ready never depends on valid.
    always_comb begin
`ifdef REGFILE_ARB_DROP_R0_EN
        drop_a = full_a_q && (addr_a_q == '0);
        drop_b = full_b_q && (addr_b_q == '0);
`else
        drop_a = 1'b0;
        drop_b = 1'b0;
`endif
        elig_a  = full_a_q && !drop_a;
        elig_b  = full_b_q && !drop_b;
        tie     = elig_a && elig_b && (age_q == AGE_NONE);
        issue_a = elig_a && (!elig_b || (age_q == AGE_A_OLD) || (tie && !rr_q));
        issue_b = elig_b && !issue_a;
    end

    assign a_ready = !full_a_q || issue_a || drop_a;
    assign b_ready = !full_b_q || issue_b || drop_b;

    // NOTE: every variable in an always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        acc_a    = a_valid && a_ready;
        acc_b    = b_valid && b_ready;
        stay_a   = full_a_q && !issue_a && !drop_a;
        stay_b   = full_b_q && !issue_b && !drop_b;
        full_a_d = acc_a || stay_a;
        full_b_d = acc_b || stay_b;
        addr_a_d = acc_a ? a_addr : addr_a_q;
        data_a_d = acc_a ? a_data : data_a_q;
        addr_b_d = acc_b ? b_addr : addr_b_q;
        data_b_d = acc_b ? b_data : data_b_q;

        // A buffer that was already full and stays full is older than one that just filled.
        age_d = AGE_NONE;
        if (full_a_d && full_b_d) begin
            if (stay_a && !stay_b)      age_d = AGE_A_OLD;
            else if (stay_b && !stay_a) age_d = AGE_B_OLD;
            else if (stay_a && stay_b)  age_d = age_q;
        end

        rr_d = rr_q ^ tie;

        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (issue_a) begin
            a3_d  = addr_a_q;
            wd3_d = data_a_q;
        end else if (issue_b) begin
            a3_d  = addr_b_q;
            wd3_d = data_b_q;
        end
    end

    // Next-state decode of the output FSM.
    always_comb begin
        state_d = IDLE;
        if (issue_a)      state_d = WR_A;
        else if (issue_b) state_d = WR_B;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            age_q    <= AGE_NONE;
            rr_q     <= 1'b0;
            full_a_q <= 1'b0;
            full_b_q <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
        end else begin
            state_q  <= state_d;
            age_q    <= age_d;
            rr_q     <= rr_d;
            full_a_q <= full_a_d;
            full_b_q <= full_b_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
        end
    end

    // NOTE: buffer payload is only ever read while its full flag is set, so it carries no reset.
    always_ff @(posedge CLK) begin
        addr_a_q <= addr_a_d;
        data_a_q <= data_a_d;
        addr_b_q <= addr_b_d;
        data_b_q <= data_b_d;
    end

    // Output decode of the FSM.
    always_comb begin
        WE3 = (state_q != IDLE);
        A3  = a3_q;
        WD3 = wd3_q;
    end

    assign busy = full_a_q || full_b_q || WE3;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter: scoreboard of expected writes in acceptance order,
// plus a small register-file model fed by the write port.
module tb_regfile_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGFILE_ARB_DROP_R0_EN
    localparam bit DROP_R0 = 1'b1;
`else
    localparam bit DROP_R0 = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic          WE3;
    logic          busy;

    regfile_write_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .A3(A3), .WD3(WD3), .WE3(WE3), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [DW-1:0] regs [32];
    logic [AW-1:0] last_addr;
    bit            exp_rr;
    int            checks   = 0;
    int            failures = 0;
    int            we3_seen = 0;
    bit            acc_a_last, acc_b_last;

    // Every WE3 pulse must match the oldest outstanding expected write.
    always @(negedge CLK) begin
        if (WE3 === 1'b1) begin
            we3_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got A3=%0d WD3=%h, expected no write", A3, WD3);
            end else begin
                mon_e = exp_q.pop_front();
                last_addr = mon_e.addr;
                if (A3 !== mon_e.addr || WD3 !== mon_e.data) begin
                    failures++;
                    $display("FAIL write_order: got A3=%0d WD3=%h, expected A3=%0d WD3=%h",
                             A3, WD3, mon_e.addr, mon_e.data);
                end
                regs[A3] = WD3;
            end
        end
    end

    function automatic bit will_issue(input logic [AW-1:0] addr);
        return !(DROP_R0 && addr == '0);
    endfunction

    // One clock: record what is accepted at the coming edge, then return at the next falling edge.
    task automatic cycle();
        bit acc_a, acc_b;
        acc_a = a_valid && a_ready && !RESET;
        acc_b = b_valid && b_ready && !RESET;
        if (acc_a && acc_b) begin
            if (!exp_rr) begin
                if (will_issue(a_addr)) exp_q.push_back(wr_t'{addr: a_addr, data: a_data});
                if (will_issue(b_addr)) exp_q.push_back(wr_t'{addr: b_addr, data: b_data});
            end else begin
                if (will_issue(b_addr)) exp_q.push_back(wr_t'{addr: b_addr, data: b_data});
                if (will_issue(a_addr)) exp_q.push_back(wr_t'{addr: a_addr, data: a_data});
            end
            exp_rr = !exp_rr;
        end else if (acc_a) begin
            if (will_issue(a_addr)) exp_q.push_back(wr_t'{addr: a_addr, data: a_data});
        end else if (acc_b) begin
            if (will_issue(b_addr)) exp_q.push_back(wr_t'{addr: b_addr, data: b_data});
        end
        acc_a_last = acc_a;
        acc_b_last = acc_b;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        idle_inputs();
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 50) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain: got %0d writes outstanding busy=%b, expected 0 and busy=0",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        idle_inputs();
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
        cycle();
        cycle();
        exp_q.delete();
        exp_rr = 1'b0;
        checks++;
        if (WE3 !== 1'b0 || A3 !== '0 || WD3 !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got WE3=%b A3=%0d WD3=%h, expected 0 0 0", WE3, A3, WD3);
        end
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got a_ready=%b b_ready=%b, expected 1 1", a_ready, b_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        RESET = 1'b0;
    endtask

    task automatic test_single_a();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEAD_BEEF;
        cycle();
        idle_inputs();
        checks++;
        if (WE3 !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_accept_edge: got WE3=%b busy=%b, expected WE3=0 busy=1", WE3, busy);
        end
        cycle();
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_issue: got WE3=%b A3=%0d WD3=%h, expected 1 3 deadbeef", WE3, A3, WD3);
        end
        cycle();
        checks++;
        if (WE3 !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse: got WE3=%b one cycle later, expected 0", WE3);
        end
        checks++;
        if (regs[3] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_reg3: got %h, expected deadbeef", regs[3]);
        end
        wait_drain("single");
    endtask

    task automatic test_tie();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd1) begin
            failures++;
            $display("FAIL tie1_first: got WE3=%b A3=%0d, expected 1 1", WE3, A3);
        end
        cycle();
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd2) begin
            failures++;
            $display("FAIL tie1_second: got WE3=%b A3=%0d, expected 1 2", WE3, A3);
        end
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd4) begin
            failures++;
            $display("FAIL tie2_first: got WE3=%b A3=%0d, expected 1 4 (port B)", WE3, A3);
        end
        cycle();
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd3) begin
            failures++;
            $display("FAIL tie2_second: got WE3=%b A3=%0d, expected 1 3", WE3, A3);
        end
        wait_drain("tie");
    endtask

    task automatic test_same_addr_order();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
        cycle();
        a_addr = 5'd6; a_data = 32'h66;
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hB;
        cycle();
        b_valid = 1'b0;
        a_addr = 5'd5; a_data = 32'hA;
        checks++;
        if (b_ready !== 1'b0 || a_ready !== 1'b1) begin
            failures++;
            $display("FAIL order_stall: got a_ready=%b b_ready=%b, expected 1 0", a_ready, b_ready);
        end
        cycle();
        wait_drain("order");
        checks++;
        if (regs[5] !== 32'hA) begin
            failures++;
            $display("FAIL order_reg5: got %h, expected 0000000a", regs[5]);
        end
    endtask

    task automatic test_back_to_back();
        int ia, ib, low_a, low_b, max_low, we3_miss, start_seen;
        ia = 0; ib = 0; low_a = 0; low_b = 0; max_low = 0; we3_miss = 0;
        start_seen = we3_seen;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA000_0000 + ia;
            b_valid = 1'b1; b_addr = 5'd20; b_data = 32'hB000_0000 + ib;
            low_a = a_ready ? 0 : low_a + 1;
            low_b = b_ready ? 0 : low_b + 1;
            if (low_a > max_low) max_low = low_a;
            if (low_b > max_low) max_low = low_b;
            cycle();
            if (acc_a_last) ia++;
            if (acc_b_last) ib++;
            if (i > 0 && WE3 !== 1'b1) we3_miss++;
        end
        idle_inputs();
        checks++;
        if (we3_miss != 0) begin
            failures++;
            $display("FAIL stream_we3: got %0d idle cycles, expected 0", we3_miss);
        end
        checks++;
        if (max_low > 1) begin
            failures++;
            $display("FAIL stream_ready: got ready low %0d cycles in a row, expected at most 1", max_low);
        end
        checks++;
        if (ia + ib != 11) begin
            failures++;
            $display("FAIL stream_accepts: got %0d transfers, expected 11", ia + ib);
        end
        wait_drain("stream");
        checks++;
        if (we3_seen - start_seen != ia + ib) begin
            failures++;
            $display("FAIL stream_writes: got %0d writes, expected %0d", we3_seen - start_seen, ia + ib);
        end
    endtask

    task automatic test_addr0();
        logic [AW-1:0] held;
        held = last_addr;
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h55;
        cycle();
        idle_inputs();
        if (DROP_R0) begin
            cycle();
            checks++;
            if (WE3 !== 1'b0 || busy !== 1'b0 || A3 !== held) begin
                failures++;
                $display("FAIL addr0_drop: got WE3=%b busy=%b A3=%0d, expected 0 0 %0d",
                         WE3, busy, A3, held);
            end
            checks++;
            if (regs[0] !== '0) begin
                failures++;
                $display("FAIL addr0_reg0: got %h, expected 00000000", regs[0]);
            end
        end else begin
            wait_drain("addr0");
            checks++;
            if (regs[0] !== 32'h55) begin
                failures++;
                $display("FAIL addr0_reg0: got %h, expected 00000055", regs[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h1212;
        b_valid = 1'b1; b_addr = 5'd13; b_data = 32'h1313;
        cycle();
        a_addr = 5'd14; a_data = 32'h1414;
        RESET = 1'b1;
        exp_q.delete();
        exp_rr = 1'b0;
        cycle();
        checks++;
        if (WE3 !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got WE3=%b a_ready=%b b_ready=%b busy=%b, expected 0 1 1 0",
                     WE3, a_ready, b_ready, busy);
        end
        RESET = 1'b0;
        idle_inputs();
        cycle();
        cycle();
        checks++;
        if (WE3 !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ignored_accept: got WE3=%b busy=%b, expected 0 0", WE3, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        last_addr = '0;
        exp_rr = 1'b0;
        RESET = 1'b1;
        idle_inputs();
        @(negedge CLK);
        test_reset();
        test_single_a();
        test_tie();
        test_same_addr_order();
        test_back_to_back();
        test_addr0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
